// File: rtl/cc_levelsequencer_p2_if.sv
// cc_levelsequencer_p2_if: control inputs and row/level outputs of the player-2 level sequencer
interface cc_levelsequencer_p2_if;
  logic       CC_LEVELSEQUENCER_P2_Start_In;
  logic       CC_LEVELSEQUENCER_P2_Tick_In;
  logic       CC_LEVELSEQUENCER_P2_Pause_In;
  logic       CC_LEVELSEQUENCER_P2_Crash_In;
  logic [4:0] CC_LEVELSEQUENCER_P2_Progress;
  logic [2:0] CC_LEVELSEQUENCER_P2_Current;
  logic       CC_LEVELSEQUENCER_P2_RowValid;
  logic       CC_LEVELSEQUENCER_P2_LevelDone;
  logic       CC_LEVELSEQUENCER_P2_Win;
  modport master (
    output CC_LEVELSEQUENCER_P2_Start_In, CC_LEVELSEQUENCER_P2_Tick_In,
           CC_LEVELSEQUENCER_P2_Pause_In, CC_LEVELSEQUENCER_P2_Crash_In,
    input  CC_LEVELSEQUENCER_P2_Progress, CC_LEVELSEQUENCER_P2_Current,
           CC_LEVELSEQUENCER_P2_RowValid, CC_LEVELSEQUENCER_P2_LevelDone, CC_LEVELSEQUENCER_P2_Win
  );
  modport slave (
    input  CC_LEVELSEQUENCER_P2_Start_In, CC_LEVELSEQUENCER_P2_Tick_In,
           CC_LEVELSEQUENCER_P2_Pause_In, CC_LEVELSEQUENCER_P2_Crash_In,
    output CC_LEVELSEQUENCER_P2_Progress, CC_LEVELSEQUENCER_P2_Current,
           CC_LEVELSEQUENCER_P2_RowValid, CC_LEVELSEQUENCER_P2_LevelDone, CC_LEVELSEQUENCER_P2_Win
  );
endinterface

// File: rtl/cc_levelsequencer_p2.sv
// cc_levelsequencer_p2: steps row/level codes for player 2 on scroll ticks, with gap rows, crash rewind and win
module cc_levelsequencer_p2 #(
  parameter int TICKS_PER_ROW = 4,
  parameter int LV1_LEN = 10,
  parameter int LV2_LEN = 15,
  parameter int LV3_LEN = 20,
  parameter int LEVEL_GAP = 3,
  parameter int REWIND = 2
) (
  input logic CC_LEVELSEQUENCER_P2_CLOCK_50,
  input logic CC_LEVELSEQUENCER_P2_RESET_InHigh,
  cc_levelsequencer_p2_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, GAP, WIN} state_t;
  state_t state;
  logic [7:0] cnt;
  logic [2:0] gap;
  logic [4:0] prog, len, rew_sat;
  logic [2:0] cur;
  logic row_valid, level_done, win, tick_ok, adv, start;
  logic signed [5:0] rew;
  always_comb begin
    start = bus.CC_LEVELSEQUENCER_P2_Start_In;
    len = cur == 3'd4 ? 5'(LV2_LEN) : cur == 3'd6 ? 5'(LV3_LEN) : 5'(LV1_LEN);
    tick_ok = bus.CC_LEVELSEQUENCER_P2_Tick_In && !bus.CC_LEVELSEQUENCER_P2_Pause_In;
    adv = tick_ok && cnt == 8'(TICKS_PER_ROW - 1);
    rew = $signed({1'b0, prog}) - $signed(6'(REWIND));
    rew_sat = rew < 6'sd1 ? 5'd1 : 5'(rew);
  end
  always_ff @(posedge CC_LEVELSEQUENCER_P2_CLOCK_50) begin
    if (CC_LEVELSEQUENCER_P2_RESET_InHigh) begin
      state <= IDLE;
      cnt <= '0;
      gap <= '0;
      prog <= '0;
      cur <= '0;
      row_valid <= 1'b0;
      level_done <= 1'b0;
      win <= 1'b0;
    end else begin
      row_valid <= 1'b0;
      level_done <= 1'b0;
      case (state)
        IDLE, WIN: begin
          cnt <= '0;
          if (start) begin
            state <= RUN;
            cur <= 3'd2;
            prog <= 5'd1;
            row_valid <= 1'b1;
            win <= 1'b0;
          end
        end
        RUN: begin
          if (bus.CC_LEVELSEQUENCER_P2_Crash_In) begin
            cnt <= '0;
            prog <= rew_sat;
            row_valid <= rew_sat != prog;
          end else begin
            if (tick_ok) cnt <= adv ? 8'd0 : cnt + 8'd1;
            if (adv) begin
              row_valid <= 1'b1;
              if (prog < len) prog <= prog + 5'd1;
              else begin
                level_done <= 1'b1;
                prog <= '0;
                if (cur == 3'd6) begin
                  state <= WIN;
                  cur <= '0;
                  win <= 1'b1;
                end else begin
                  state <= GAP;
                  gap <= 3'd1;
                end
              end
            end
          end
        end
        GAP: begin
          if (tick_ok) cnt <= adv ? 8'd0 : cnt + 8'd1;
          if (adv) begin
            row_valid <= 1'b1;
            if (gap < 3'(LEVEL_GAP)) gap <= gap + 3'd1;
            else begin
              state <= RUN;
              cur <= cur + 3'd2;
              prog <= 5'd1;
              gap <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.CC_LEVELSEQUENCER_P2_Progress = prog;
  assign bus.CC_LEVELSEQUENCER_P2_Current = cur;
  assign bus.CC_LEVELSEQUENCER_P2_RowValid = row_valid;
  assign bus.CC_LEVELSEQUENCER_P2_LevelDone = level_done;
  assign bus.CC_LEVELSEQUENCER_P2_Win = win;
endmodule
